fifo_async: RTL and testbench

FIFO_ASYNC -- requirements
Module: fifo_async

---
 rtl/fifo_async_pkg.sv | 12 +
 rtl/fifo_async_sync_2ff.sv | 27 ++
 rtl/fifo_async.sv | 110 +++++++++++
 tb/tb_fifo_async.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_async_pkg.sv
// Shared defaults and the binary-to-Gray helper for the dual-clock FIFO.
package fifo_async_pkg;

  localparam int unsigned FIFO_DEF_WIDTH = 8;
  localparam int unsigned FIFO_DEF_DEPTH = 8;

  // Callers zero-extend narrower pointers; the low bits of the result are unaffected.
  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/fifo_async_sync_2ff.sv
// Two-stage synchronizer for Gray-coded pointers entering another clock domain.
// Latency two destination clocks; no flow control.
module sync_2ff #(
  parameter int unsigned W = 1
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/fifo_async.sv
// Dual-clock FIFO with Gray-pointer crossing; read data one rd_clk after an accepted read.
// Writes while full and reads while empty are dropped; flags clear 2-3 clocks late.
module fifo_async
  import fifo_async_pkg::*;
#(
  parameter int unsigned WIDTH = FIFO_DEF_WIDTH,
  parameter int unsigned DEPTH = FIFO_DEF_DEPTH
) (
  input  logic             wr_clk,
  input  logic             wrst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_clk,
  input  logic             rrst_n,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0] wbin_q, wbin_d;
  logic [PW-1:0] wgray_q, wgray_d;
  logic          full_q, full_d;
  logic [PW-1:0] rgray_wsync;
  logic          wr_fire;

  logic [PW-1:0]    rbin_q, rbin_d;
  logic [PW-1:0]    rgray_q, rgray_d;
  logic             empty_q, empty_d;
  logic [WIDTH-1:0] rd_data_q;
  logic [PW-1:0]    wgray_rsync;
  logic             rd_fire;

  // Write domain
  assign wr_fire = wr_en & ~full_q;

  always_comb begin
    wbin_d  = wbin_q + PW'(wr_fire);
    wgray_d = PW'(bin2gray(32'(wbin_d)));
    // Full when the writer is exactly one lap ahead: top two Gray bits inverted.
    full_d  = (wgray_d == {~rgray_wsync[PW-1 -: 2], rgray_wsync[PW-3:0]});
  end

  always_ff @(posedge wr_clk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      full_q  <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      full_q  <= full_d;
    end
  end

  always_ff @(posedge wr_clk) begin
    if (wr_fire) begin
      mem_q[wbin_q[AW-1:0]] <= wr_data;
    end
  end

  sync_2ff #(.W(PW)) u_sync_r2w (
    .clk_i   (wr_clk),
    .rst_n_i (wrst_n),
    .d_i     (rgray_q),
    .q_o     (rgray_wsync)
  );

  // Read domain
  assign rd_fire = rd_en & ~empty_q;

  always_comb begin
    rbin_d  = rbin_q + PW'(rd_fire);
    rgray_d = PW'(bin2gray(32'(rbin_d)));
    empty_d = (rgray_d == wgray_rsync);
  end

  always_ff @(posedge rd_clk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin_q    <= '0;
      rgray_q   <= '0;
      empty_q   <= 1'b1;
      rd_data_q <= '0;
    end else begin
      rbin_q  <= rbin_d;
      rgray_q <= rgray_d;
      empty_q <= empty_d;
      if (rd_fire) begin
        rd_data_q <= mem_q[rbin_q[AW-1:0]];
      end
    end
  end

  sync_2ff #(.W(PW)) u_sync_w2r (
    .clk_i   (rd_clk),
    .rst_n_i (rrst_n),
    .d_i     (wgray_q),
    .q_o     (wgray_rsync)
  );

  assign full    = full_q;
  assign empty   = empty_q;
  assign rd_data = rd_data_q;

endmodule

// File: tb/tb_fifo_async.sv
// Scoreboard bench for fifo_async: writers queue expected words, a read-side monitor pops and compares.
module tb_fifo_async;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;

  logic             wr_clk = 1'b0;
  logic             rd_clk = 1'b0;
  logic             wrst_n, rrst_n;
  logic             wr_en, rd_en;
  logic [WIDTH-1:0] wr_data, rd_data;
  logic             full, empty;

  int checks = 0;
  int errors = 0;
  int rd_count = 0;
  logic [WIDTH-1:0] sb [$];
  logic [WIDTH-1:0] last_rd = '0;
  event wr_first, rd_first;

  fifo_async #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .wr_clk  (wr_clk),
    .wrst_n  (wrst_n),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_clk  (rd_clk),
    .rrst_n  (rrst_n),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty)
  );

  always #30 wr_clk = ~wr_clk;
  always #25 rd_clk = ~rd_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: an accepted read must show the oldest queued word; otherwise rd_data holds.
  always @(posedge rd_clk) begin
    logic fire;
    fire = rrst_n && rd_en && !empty;
    #1;
    if (!rrst_n) begin
      last_rd = '0;
    end else if (fire) begin
      rd_count++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL read_underflow: got %0h expected no read at %0t", rd_data, $time);
      end else begin
        last_rd = sb.pop_front();
        chk("rd_data", rd_data, last_rd);
      end
    end else begin
      chk("rd_hold", rd_data, last_rd);
    end
  end

  task automatic wr_word(input logic [WIDTH-1:0] d, input bit accept);
    @(negedge wr_clk);
    wr_en   = 1'b1;
    wr_data = d;
    if (accept) sb.push_back(d);
    @(posedge wr_clk);
  endtask

  task automatic wr_idle();
    @(negedge wr_clk);
    wr_en = 1'b0;
  endtask

  task automatic rd_pulse();
    @(negedge rd_clk);
    rd_en = 1'b1;
    @(posedge rd_clk);
  endtask

  task automatic rd_idle();
    @(negedge rd_clk);
    rd_en = 1'b0;
  endtask

  task automatic rd_when_ready(input string name);
    int n;
    n = 0;
    @(negedge rd_clk);
    while (empty && n < 10) begin
      @(negedge rd_clk);
      n++;
    end
    chk(name, empty, 0);
    rd_en = 1'b1;
    @(posedge rd_clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
    wrst_n = 1'b0; rrst_n = 1'b0;
    #100;
    chk("reset_empty", empty, 1);
    chk("reset_full", full, 0);
    chk("reset_rd_data", rd_data, 0);
    #210;
    wrst_n = 1'b1; rrst_n = 1'b1;
    repeat (3) @(posedge wr_clk);

    // Fill with 8 consecutive writes; empty must clear within 3 rd_clk.
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          wr_word(8'hA0 + 8'(i), 1'b1);
          #1;
          chk("full_fill", full, (i == 7));
          if (i == 0) ->wr_first;
        end
        wr_idle();
      end
      begin
        int n;
        @(wr_first);
        n = 0;
        while (empty && n < 4) begin
          @(posedge rd_clk);
          #1;
          n++;
        end
        chk("empty_clear_within_3", (n <= 3) ? 1 : 0, 1);
      end
    join
    repeat (4) @(posedge rd_clk);

    // Drain 8; full must clear within 3 wr_clk of the first read.
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          rd_pulse();
          #1;
          chk("empty_drain", empty, (i == 7));
          if (i == 0) ->rd_first;
        end
        rd_idle();
      end
      begin
        int n;
        @(rd_first);
        n = 0;
        while (full && n < 4) begin
          @(posedge wr_clk);
          #1;
          n++;
        end
        chk("full_clear_within_3", (n <= 3) ? 1 : 0, 1);
      end
    join
    repeat (4) @(posedge wr_clk);

    // Overflow: 16 writes, only the first 8 are kept.
    for (int i = 0; i < 16; i++) begin
      wr_word(8'h30 + 8'(i), (i < 8));
      #1;
      chk("full_ovf", full, (i >= 7));
    end
    wr_idle();
    repeat (4) @(posedge rd_clk);
    for (int i = 0; i < 8; i++) rd_pulse();
    #1;
    chk("empty_after_ovf_drain", empty, 1);
    rd_pulse();
    #1;
    chk("empty_read_on_empty", empty, 1);
    rd_idle();
    repeat (4) @(posedge wr_clk);
    chk("full_after_ovf_drain", full, 0);

    // Concurrent streaming of 100 words.
    base = rd_count;
    fork
      begin
        int i, cyc;
        i = 0; cyc = 0;
        while (i < 100 && cyc < 3000) begin
          @(negedge wr_clk);
          cyc++;
          if (!full) begin
            wr_en   = 1'b1;
            wr_data = 8'(i) ^ 8'h5A;
            sb.push_back(wr_data);
            i++;
          end else begin
            wr_en = 1'b0;
          end
        end
        @(negedge wr_clk);
        wr_en = 1'b0;
      end
      begin
        int cyc;
        cyc = 0;
        while (rd_count - base < 100 && cyc < 3000) begin
          @(negedge rd_clk);
          rd_en = ((cyc % 5) != 2);
          cyc++;
        end
        rd_en = 1'b0;
      end
    join
    chk("stream_count", rd_count - base, 100);
    chk("stream_sb_empty", sb.size(), 0);
    repeat (4) @(posedge wr_clk);

    // Reset both sides with 5 words stored.
    for (int i = 0; i < 5; i++) wr_word(8'h70 + 8'(i), 1'b1);
    wr_idle();
    repeat (5) @(posedge rd_clk);
    @(negedge rd_clk);
    chk("empty_before_reset", empty, 0);
    @(negedge wr_clk);
    #7;
    wrst_n = 1'b0; rrst_n = 1'b0;
    sb.delete();
    #1;
    chk("midreset_empty", empty, 1);
    chk("midreset_full", full, 0);
    chk("midreset_rd_data", rd_data, 0);
    repeat (3) @(negedge wr_clk);
    #7;
    wrst_n = 1'b1; rrst_n = 1'b1;
    repeat (3) @(posedge wr_clk);
    wr_word(8'hC3, 1'b1);
    wr_idle();
    rd_when_ready("empty_before_new_read");
    rd_idle();
    rd_pulse();
    #1;
    chk("empty_after_reset_read", empty, 1);
    rd_idle();
    repeat (3) @(posedge rd_clk);
    chk("final_sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
